// File: rtl/io_dma_ctrl.sv
// Interrupt-driven burst reader: acknowledges a rising Int_req, reads BURST_LEN words
// over the active-low CS_/RD_ bus into a show-ahead FIFO drained by a valid/ready stream.
module io_dma_ctrl #(
   parameter int                ADDR_W     = 10,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                BURST_LEN  = 8,
   parameter int                FIFO_DEPTH = 16
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Enable,
   input  logic                         Int_req,
   output logic                         Int_ack,
   output logic                         CS_,
   output logic                         RD_,
   output logic                         WR_,
   output logic [ADDR_W-1:0]            Addr,
   input  logic [DATA_W-1:0]            Data,
   output logic [DATA_W-1:0]            Dout,
   output logic                         Dout_valid,
   input  logic                         Dout_ready,
   output logic                         Busy,
   output logic                         Burst_done,
   output logic [$clog2(FIFO_DEPTH):0]  Fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_READ = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                int_req_d_q;
   logic                pending_q, pending_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                int_ack_q, burst_done_q, busy_q, cs_n_q, rd_n_q;
   logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

   logic rise_s, req_s, push_s, pop_s, full_s;

   always_comb begin
      rise_s    = Int_req & ~int_req_d_q;
      req_s     = rise_s & Enable;
      full_s    = (count_q == FULL_CNT);
      push_s    = (state_q == S_READ) && !full_s;
      pop_s     = (count_q != '0) && Dout_ready;
      state_d   = state_q;
      pending_d = pending_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      case (state_q)
         S_IDLE: begin
            if (pending_q || req_s) begin
               state_d   = S_ACK;
               pending_d = 1'b0;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ACK: begin
            state_d   = S_READ;
            pending_d = pending_q | req_s;
         end
         S_READ: begin
            pending_d = pending_q | req_s;
            if (push_s) begin
               ptr_d = ptr_q + ADDR_W'(1);
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else begin
               // FIFO full: keep the bus asserted on the same address until space frees up
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            pending_d = pending_q | req_s;
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         int_req_d_q  <= 1'b0;
         pending_q    <= 1'b0;
         ptr_q        <= BASE_ADDR;
         idx_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         int_ack_q    <= 1'b0;
         burst_done_q <= 1'b0;
         busy_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         rd_n_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         int_req_d_q  <= Int_req;
         pending_q    <= pending_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         int_ack_q    <= (state_d == S_ACK);
         burst_done_q <= (state_d == S_DONE);
         busy_q       <= (state_d != S_IDLE);
         cs_n_q       <= (state_d != S_READ);
         rd_n_q       <= (state_d != S_READ);
      end
   end

   // Storage needs no reset: emptiness is tracked by the pointers and count alone
   always_ff @(posedge Clk) begin
      if (push_s && !Reset) begin
         fifo_mem_q[wr_ptr_q] <= Data;
      end
   end

   assign Int_ack    = int_ack_q;
   assign Burst_done = burst_done_q;
   assign Busy       = busy_q;
   assign CS_        = cs_n_q;
   assign RD_        = rd_n_q;
   assign WR_        = 1'b1;
   assign Addr       = ptr_q;
   assign Dout       = fifo_mem_q[rd_ptr_q];
   assign Dout_valid = (count_q != '0);
   assign Fifo_count = count_q;

endmodule

// File: tb/tb_io_dma_ctrl.sv
// Directed bench for io_dma_ctrl: a second instance with BASE_ADDR=3FC exercises pointer wrap.
module tb_io_dma_ctrl;

   logic        Clk = 1'b0, Reset = 1'b1, Enable = 1'b1, Int_req = 1'b0, Dout_ready = 1'b1;
   logic        Int_ack, CS_, RD_, WR_, Dout_valid, Busy, Burst_done;
   logic [9:0]  Addr;
   logic [31:0] Data, Dout;
   logic [4:0]  Fifo_count;
   logic        Int_ack_w, CS_w, RD_w, WR_w, Dout_valid_w, Busy_w, Burst_done_w;
   logic [9:0]  Addr_w;
   logic [31:0] Data_w, Dout_w;
   logic [4:0]  Fifo_count_w;

   int n_checks = 0;
   int n_errors = 0;
   int exp_idx  = 0;

   // IO memory model: mem[i] = A000_0000 + i, only driven while selected
   assign Data   = (!CS_   && !RD_)   ? (32'hA000_0000 + {22'd0, Addr})   : 32'hDEAD_BEEF;
   assign Data_w = (!CS_w  && !RD_w)  ? (32'hA000_0000 + {22'd0, Addr_w}) : 32'hDEAD_BEEF;

   io_dma_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(10'h000), .BURST_LEN(8), .FIFO_DEPTH(16)) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Int_req(Int_req), .Int_ack(Int_ack),
      .CS_(CS_), .RD_(RD_), .WR_(WR_), .Addr(Addr), .Data(Data), .Dout(Dout),
      .Dout_valid(Dout_valid), .Dout_ready(Dout_ready), .Busy(Busy),
      .Burst_done(Burst_done), .Fifo_count(Fifo_count)
   );

   io_dma_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(10'h3FC), .BURST_LEN(8), .FIFO_DEPTH(16)) dut_w (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Int_req(Int_req), .Int_ack(Int_ack_w),
      .CS_(CS_w), .RD_(RD_w), .WR_(WR_w), .Addr(Addr_w), .Data(Data_w), .Dout(Dout_w),
      .Dout_valid(Dout_valid_w), .Dout_ready(Dout_ready), .Busy(Busy_w),
      .Burst_done(Burst_done_w), .Fifo_count(Fifo_count_w)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; words leaving the stream on this edge are checked against the in-order model
   task automatic tick();
      if (!Reset && Dout_valid && Dout_ready) begin
         chk("pop_order", Dout, 32'hA000_0000 + 32'(exp_idx));
         exp_idx++;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic rise();
      Int_req = 1'b0;
      tick();
      Int_req = 1'b1;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 40 && !Burst_done; k++) tick();
      chk("burst_done_seen", Burst_done, 32'd1);
   endtask

   task automatic burst(input logic [9:0] a0, input logic [9:0] aw0);
      rise();
      tick();
      chk("ack_high", Int_ack, 32'd1);
      chk("busy_in_ack", Busy, 32'd1);
      chk("cs_idle_in_ack", CS_, 32'd1);
      tick();
      chk("ack_one_cycle", Int_ack, 32'd0);
      for (int i = 0; i < 8; i++) begin
         logic [9:0] a;
         logic [9:0] aw;
         a  = a0 + 10'(i);
         aw = aw0 + 10'(i);
         chk("addr", {22'd0, Addr}, {22'd0, a});
         chk("cs_low", CS_, 32'd0);
         chk("rd_low", RD_, 32'd0);
         chk("addr_wrap", {22'd0, Addr_w}, {22'd0, aw});
         tick();
         chk("dout", Dout, 32'hA000_0000 + {22'd0, a});
         chk("fifo_count_stream", {27'd0, Fifo_count}, 32'd1);
         chk("dout_wrap", Dout_w, 32'hA000_0000 + {22'd0, aw});
      end
      chk("burst_done_pulse", Burst_done, 32'd1);
      chk("cs_released", CS_, 32'd1);
      tick();
      chk("burst_done_one_cycle", Burst_done, 32'd0);
      chk("busy_cleared", Busy, 32'd0);
      chk("fifo_drained", {27'd0, Fifo_count}, 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_cs", CS_, 32'd1);
      chk("rst_rd", RD_, 32'd1);
      chk("rst_wr", WR_, 32'd1);
      chk("rst_ack", Int_ack, 32'd0);
      chk("rst_addr", {22'd0, Addr}, 32'd0);
      chk("rst_valid", Dout_valid, 32'd0);
      chk("rst_busy", Busy, 32'd0);
      chk("rst_done", Burst_done, 32'd0);
      chk("rst_count", {27'd0, Fifo_count}, 32'd0);
      chk("rst_addr_w", {22'd0, Addr_w}, 32'h3FC);
      chk("rst_wr_w", WR_w, 32'd1);
      chk("rst_idle_w", {Int_ack_w, Busy_w, Burst_done_w, Dout_valid_w}, 32'd0);
      chk("rst_count_w", {27'd0, Fifo_count_w}, 32'd0);
      Reset = 1'b0;

      // First burst (0..7) and wrapping burst (3FC..003); second burst continues pointer
      burst(10'h000, 10'h3FC);
      burst(10'h008, 10'h004);

      // Back-pressure: fill FIFO, stall third burst at address 0x10, then drain 24 words
      Int_req = 1'b0; Reset = 1'b1; tick(); Reset = 1'b0; exp_idx = 0; Dout_ready = 1'b0;
      rise(); wait_done();
      rise(); wait_done();
      tick();
      chk("fifo_full_count", {27'd0, Fifo_count}, 32'd16);
      chk("fifo_head", Dout, 32'hA000_0000);
      rise(); tick(); tick();
      chk("stall_addr", {22'd0, Addr}, 32'h010);
      chk("stall_cs", CS_, 32'd0);
      chk("stall_count", {27'd0, Fifo_count}, 32'd16);
      tick(); tick();
      chk("stall_addr_held", {22'd0, Addr}, 32'h010);
      chk("stall_rd", RD_, 32'd0);
      chk("stall_busy", Busy, 32'd1);
      Dout_ready = 1'b1;
      for (int k = 0; k < 80 && !(exp_idx >= 24 && Fifo_count == 5'd0); k++) tick();
      chk("drain_total", 32'(exp_idx), 32'd24);
      chk("drain_count", {27'd0, Fifo_count}, 32'd0);
      chk("drain_busy", Busy, 32'd0);

      // Two rises during a burst give exactly one extra burst
      Int_req = 1'b0; Reset = 1'b1; tick(); Reset = 1'b0; exp_idx = 0;
      rise(); tick(); tick();
      Int_req = 1'b0; tick(); Int_req = 1'b1; tick();
      Int_req = 1'b0; tick(); Int_req = 1'b1; tick();
      wait_done();
      tick();
      chk("pend_idle_busy", Busy, 32'd0);
      chk("pend_idle_ack", Int_ack, 32'd0);
      tick();
      chk("pend_ack", Int_ack, 32'd1);
      wait_done();
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("pend_no_third", Int_ack, 32'd0);
      end
      chk("pend_busy_end", Busy, 32'd0);
      chk("pend_words", 32'(exp_idx), 32'd16);

      // Reset after three pushes; Int_req held high counts as a rise after release
      Int_req = 1'b0; Reset = 1'b1; tick(); Reset = 1'b0; exp_idx = 0; Dout_ready = 1'b0;
      rise(); tick(); tick(); tick(); tick(); tick();
      chk("mid_count", {27'd0, Fifo_count}, 32'd3);
      chk("mid_addr", {22'd0, Addr}, 32'd3);
      Reset = 1'b1;
      tick();
      chk("mrst_count", {27'd0, Fifo_count}, 32'd0);
      chk("mrst_addr", {22'd0, Addr}, 32'd0);
      chk("mrst_bus", {CS_, RD_, WR_}, 32'd7);
      chk("mrst_flags", {Int_ack, Busy, Burst_done, Dout_valid}, 32'd0);
      Reset = 1'b0; Dout_ready = 1'b1; exp_idx = 0;
      tick();
      chk("mrst_rise_ack", Int_ack, 32'd1);
      tick();
      chk("mrst_base_addr", {22'd0, Addr}, 32'd0);
      chk("mrst_base_cs", CS_, 32'd0);
      wait_done();
      tick();
      chk("mrst_words", 32'(exp_idx), 32'd8);
      chk("mrst_busy", Busy, 32'd0);

      // Rises while disabled are ignored and leave nothing pending
      Int_req = 1'b0; tick();
      Enable = 1'b0; Int_req = 1'b1;
      tick();
      chk("dis_ack", Int_ack, 32'd0);
      chk("dis_busy", Busy, 32'd0);
      chk("dis_cs", CS_, 32'd1);
      tick(); tick();
      Enable = 1'b1;
      tick(); tick(); tick();
      chk("en_no_ack", Int_ack, 32'd0);
      chk("en_no_busy", Busy, 32'd0);
      chk("en_cs", CS_, 32'd1);
      chk("en_count", {27'd0, Fifo_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
